qsm_pixel_out: RTL



---
 rtl/qsm_pixel_out_if.sv | 17 +
 rtl/qsm_pixel_out.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/qsm_pixel_out_if.sv
// qsm_pixel_out_if: valid/ready stream bundle with an end-of-line marker.
//   valid : producer has a word on data/last
//   ready : consumer accepts the word this cycle
//   data  : WIDTH-bit payload
//   last  : end-of-line marker travelling with the word
// master = producer side, slave = consumer side.
interface qsm_pixel_out_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/qsm_pixel_out.sv
// qsm_pixel_out: output stage of the fixed-point convolution datapath.
// Converts a sign-magnitude adder-tree result into an unsigned pixel:
// rounds off the fraction bits (ties away from zero), applies the sign
// policy (magnitude or clamp-to-zero) and saturates to PIXEL_WIDTH.
// Two-stage elastic pipeline, full throughput, backpressure-safe.
//   clk, reset : clock, synchronous active-high reset
//   mode_abs   : 1 = output magnitude, 0 = negatives become 0
//   s          : input stream, FP_WORD_LENGTH-bit sign-magnitude words
//   m          : output stream, PIXEL_WIDTH-bit unsigned pixels
//   clear_sat  : one-cycle pulse clearing sat_count
//   sat_count  : sticky count of saturated output pixels (holds at 0xFFFF)
module qsm_pixel_out #(
    parameter int FP_WORD_LENGTH = 11,
    parameter int FP_FRAC_LENGTH = 0,
    parameter int PIXEL_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode_abs,
    qsm_pixel_out_if.slave         s,
    qsm_pixel_out_if.master        m,
    input  logic                   clear_sat,
    output logic [15:0]            sat_count
);
    localparam int W  = FP_WORD_LENGTH;
    localparam int MW = FP_WORD_LENGTH - 1;

    logic                   s1_valid_reg;
    logic                   s1_sgn_reg;
    logic                   s1_last_reg;
    logic [W-1:0]           s1_r_reg;
    logic                   s2_valid_reg;
    logic                   s2_sat_reg;
    logic                   s2_last_reg;
    logic [PIXEL_WIDTH-1:0] s2_pix_reg;
    logic [15:0]            sat_count_reg;

    // Handshake: each stage refills when it is empty or is being drained
    // this same cycle, so a full pipeline accepts again as soon as m.ready rises.
    logic m_take, s2_load, s1_move, s1_load, s_take;
    assign m_take  = s2_valid_reg & m.ready;
    assign s2_load = ~s2_valid_reg | m_take;
    assign s1_move = s1_valid_reg & s2_load;
    assign s1_load = ~s1_valid_reg | s1_move;
    assign s.ready = s1_load & ~reset;
    assign s_take  = s.valid & s.ready;

    // Rounding of the magnitude; one extra bit keeps the carry of the
    // half-LSB addition.
    logic [MW-1:0] in_mag;
    logic [W-1:0]  in_r;
    logic          in_sgn;
    assign in_mag = s.data[MW-1:0];

    generate
        if (FP_FRAC_LENGTH == 0) begin : g_no_round
            assign in_r = {1'b0, in_mag};
        end else begin : g_round
            localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
            localparam logic [W-1:0] HALF = ONE << (FP_FRAC_LENGTH - 1);
            logic [W-1:0] sum;
            assign sum  = {1'b0, in_mag} + HALF;
            assign in_r = sum >> FP_FRAC_LENGTH;
        end
    endgenerate

    // A negative value that rounds to zero (including -0) is treated as +0.
    assign in_sgn = s.data[W-1] & (in_r != '0);

    // Saturation detection on the rounded magnitude.
    logic                   s1_over;
    logic [PIXEL_WIDTH-1:0] s1_low;
    generate
        if (W > PIXEL_WIDTH) begin : g_sat
            assign s1_over = |s1_r_reg[W-1:PIXEL_WIDTH];
            assign s1_low  = s1_r_reg[PIXEL_WIDTH-1:0];
        end else begin : g_no_sat
            assign s1_over = 1'b0;
            assign s1_low  = PIXEL_WIDTH'(s1_r_reg);
        end
    endgenerate

    // Clamped negatives produce 0 and never count as saturation.
    logic                   neg_clamp;
    logic [PIXEL_WIDTH-1:0] pix_next;
    logic                   sat_next;
    assign neg_clamp = s1_sgn_reg & ~mode_abs;
    assign pix_next  = neg_clamp ? '0 : (s1_over ? '1 : s1_low);
    assign sat_next  = ~neg_clamp & s1_over;

    // Stage 1: rounded magnitude and cleaned-up sign.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_sgn_reg   <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_r_reg     <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= s.valid;
            if (s_take) begin
                s1_sgn_reg  <= in_sgn;
                s1_last_reg <= s.last;
                s1_r_reg    <= in_r;
            end
        end
    end

    // Stage 2: final pixel; payload only changes when a new word loads,
    // so m.data/m.last stay stable while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_sat_reg   <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_pix_reg   <= '0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_pix_reg  <= pix_next;
                s2_sat_reg  <= sat_next;
                s2_last_reg <= s1_last_reg;
            end
        end
    end

    // Sticky saturation counter; a clear coinciding with an increment
    // leaves exactly that one event counted.
    logic sat_inc;
    assign sat_inc = m_take & s2_sat_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count_reg <= '0;
        end else if (clear_sat) begin
            sat_count_reg <= sat_inc ? 16'd1 : 16'd0;
        end else if (sat_inc && sat_count_reg != 16'hFFFF) begin
            sat_count_reg <= sat_count_reg + 16'd1;
        end
    end

    assign m.valid   = s2_valid_reg;
    assign m.data    = s2_pix_reg;
    assign m.last    = s2_last_reg;
    assign sat_count = sat_count_reg;
endmodule
